// File: rtl/fir_win_acc.sv
// Sliding-window complex accumulator with scaled, narrowed results queued in a small output FIFO.
// Optional macro FIR_WIN_ACC_SAT_EN selects saturating narrowing; undefined keeps the low OUT_W bits.
module fir_win_acc #(
    parameter int DATA_W    = 16,
    parameter int OUT_W     = 16,
    parameter int MAX_WIN   = 64,
    parameter int OUT_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [$clog2(MAX_WIN):0]   cfg_win_len,
    input  logic [4:0]                 cfg_shift,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_re,
    input  logic [DATA_W-1:0]          in_im,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_re,
    output logic [OUT_W-1:0]           out_im,
    output logic                       overrun
);
    localparam int LW    = $clog2(MAX_WIN);
    localparam int ACC_W = DATA_W + LW;
    localparam int FW    = $clog2(OUT_DEPTH);

    localparam logic S_FILL = 1'b0;
    localparam logic S_RUN  = 1'b1;

    logic                     r_state;
    logic [LW:0]              r_win_len;
    logic [4:0]               r_shift;
    logic [DATA_W-1:0]        r_buf_re [MAX_WIN];
    logic [DATA_W-1:0]        r_buf_im [MAX_WIN];
    logic [LW-1:0]            r_wr_ptr;
    logic [LW:0]              r_fill_cnt;
    logic signed [ACC_W-1:0]  r_acc_re;
    logic signed [ACC_W-1:0]  r_acc_im;
    logic                     r_pend;
    logic [OUT_W-1:0]         r_fifo_re [OUT_DEPTH];
    logic [OUT_W-1:0]         r_fifo_im [OUT_DEPTH];
    logic [FW-1:0]            r_rd;
    logic [FW-1:0]            r_wr;
    logic [FW:0]              r_cnt;
    logic                     r_overrun;

    logic                     w_take;
    logic [LW-1:0]            w_old_idx;
    logic signed [ACC_W-1:0]  w_new_re, w_new_im, w_old_re, w_old_im;
    logic signed [ACC_W-1:0]  w_acc_re_nxt, w_acc_im_nxt;
    logic signed [ACC_W-1:0]  w_sh_re, w_sh_im;
    logic [LW:0]              w_cnt_nxt;
    logic                     w_full, w_pop, w_push, w_drop;

    function automatic logic [OUT_W-1:0] narrow(input logic [ACC_W-1:0] v);
`ifdef FIR_WIN_ACC_SAT_EN
        if (!v[ACC_W-1] && (|v[ACC_W-2:OUT_W-1]))
            return {1'b0, {(OUT_W-1){1'b1}}};
        else if (v[ACC_W-1] && !(&v[ACC_W-2:OUT_W-1]))
            return {1'b1, {(OUT_W-1){1'b0}}};
        else
            return v[OUT_W-1:0];
`else
        return v[OUT_W-1:0];
`endif
    endfunction

    always_comb begin
        w_take    = in_valid && !flush;
        // At full window length the oldest sample sits at wr_ptr itself.
        w_old_idx = r_wr_ptr - r_win_len[LW-1:0];
        w_new_re  = {{LW{in_re[DATA_W-1]}}, in_re};
        w_new_im  = {{LW{in_im[DATA_W-1]}}, in_im};
        w_old_re  = {{LW{r_buf_re[w_old_idx][DATA_W-1]}}, r_buf_re[w_old_idx]};
        w_old_im  = {{LW{r_buf_im[w_old_idx][DATA_W-1]}}, r_buf_im[w_old_idx]};
        if (r_state == S_RUN) begin
            w_acc_re_nxt = r_acc_re + w_new_re - w_old_re;
            w_acc_im_nxt = r_acc_im + w_new_im - w_old_im;
        end else begin
            w_acc_re_nxt = r_acc_re + w_new_re;
            w_acc_im_nxt = r_acc_im + w_new_im;
        end
        w_cnt_nxt = r_fill_cnt + (LW+1)'(1);
        w_sh_re   = r_acc_re >>> r_shift;
        w_sh_im   = r_acc_im >>> r_shift;
        w_full    = (r_cnt == (FW+1)'(OUT_DEPTH));
        w_pop     = (r_cnt != '0) && out_ready;
        w_push    = r_pend && (!w_full || w_pop);
        w_drop    = r_pend && w_full && !w_pop;
    end

    always_ff @(posedge clk) begin
        if (w_take) begin
            r_buf_re[r_wr_ptr] <= in_re;
            r_buf_im[r_wr_ptr] <= in_im;
        end
        if (w_push) begin
            r_fifo_re[r_wr] <= narrow(w_sh_re);
            r_fifo_im[r_wr] <= narrow(w_sh_im);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FILL;
            r_win_len  <= (LW+1)'(1);
            r_shift    <= '0;
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
            r_acc_re   <= '0;
            r_acc_im   <= '0;
            r_pend     <= 1'b0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_cnt      <= '0;
            r_overrun  <= 1'b0;
        end else if (flush) begin
            if (cfg_win_len == '0)
                r_win_len <= (LW+1)'(1);
            else if (cfg_win_len > (LW+1)'(MAX_WIN))
                r_win_len <= (LW+1)'(MAX_WIN);
            else
                r_win_len <= cfg_win_len;
            r_shift    <= (cfg_shift > 5'(ACC_W-1)) ? 5'(ACC_W-1) : cfg_shift;
            r_state    <= S_FILL;
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
            r_acc_re   <= '0;
            r_acc_im   <= '0;
            r_pend     <= 1'b0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_cnt      <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_pend <= 1'b0;
            if (in_valid) begin
                r_acc_re <= w_acc_re_nxt;
                r_acc_im <= w_acc_im_nxt;
                r_wr_ptr <= r_wr_ptr + LW'(1);
                if (r_state == S_FILL) begin
                    r_fill_cnt <= w_cnt_nxt;
                    if (w_cnt_nxt == r_win_len) begin
                        r_state <= S_RUN;
                        r_pend  <= 1'b1;
                    end
                end else begin
                    r_pend <= 1'b1;
                end
            end
            if (w_push)
                r_wr <= r_wr + FW'(1);
            if (w_pop)
                r_rd <= r_rd + FW'(1);
            if (w_push && !w_pop)
                r_cnt <= r_cnt + (FW+1)'(1);
            else if (w_pop && !w_push)
                r_cnt <= r_cnt - (FW+1)'(1);
            if (w_drop)
                r_overrun <= 1'b1;
        end
    end

    assign out_valid = (r_cnt != '0);
    assign out_re    = out_valid ? r_fifo_re[r_rd] : '0;
    assign out_im    = out_valid ? r_fifo_im[r_rd] : '0;
    assign overrun   = r_overrun;
endmodule

// File: tb/tb_fir_win_acc.sv
// Directed bench for fir_win_acc: a reference model pushes expected results into a scoreboard
// queue as samples are driven; a negedge monitor pops and compares whatever the FIFO delivers.
module tb_fir_win_acc;
    localparam int DATA_W    = 16;
    localparam int OUT_W     = 16;
    localparam int MAX_WIN   = 64;
    localparam int OUT_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [6:0]        cfg_win_len = '0;
    logic [4:0]        cfg_shift = '0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_re = '0;
    logic [DATA_W-1:0] in_im = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [OUT_W-1:0]  out_re;
    logic [OUT_W-1:0]  out_im;
    logic              overrun;

    int n_checks = 0;
    int n_pass   = 0;

    int                  m_win = 1;
    int                  m_shift = 0;
    int                  hist_re[$];
    int                  hist_im[$];
    logic [2*OUT_W-1:0]  exp_q[$];

    fir_win_acc #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .MAX_WIN(MAX_WIN), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .cfg_win_len(cfg_win_len), .cfg_shift(cfg_shift),
        .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [OUT_W-1:0] narrow_m(input longint s, input int sh);
        longint v;
        v = s >>> sh;
`ifdef FIR_WIN_ACC_SAT_EN
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
`endif
        return OUT_W'(v);
    endfunction

    task automatic model_in(input int re, input int im, input bit exp_on);
        longint sr, si;
        hist_re.push_back(re);
        hist_im.push_back(im);
        if (hist_re.size() >= m_win) begin
            sr = 0;
            si = 0;
            for (int j = 0; j < m_win; j++) begin
                sr += hist_re[hist_re.size()-1-j];
                si += hist_im[hist_im.size()-1-j];
            end
            if (exp_on) exp_q.push_back({narrow_m(sr, m_shift), narrow_m(si, m_shift)});
        end
    endtask

    task automatic send(input int re, input int im, input bit exp_on = 1'b1);
        in_valid = 1'b1;
        in_re = DATA_W'(re);
        in_im = DATA_W'(im);
        model_in(re, im, exp_on);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_flush(input int win, input int sh, input bit v = 1'b0, input int re = 0);
        flush = 1'b1;
        cfg_win_len = 7'(win);
        cfg_shift = 5'(sh);
        in_valid = v;
        in_re = DATA_W'(re);
        in_im = '0;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        m_win = (win == 0) ? 1 : ((win > MAX_WIN) ? MAX_WIN : win);
        m_shift = (sh > DATA_W + 5) ? DATA_W + 5 : sh;
        hist_re.delete();
        hist_im.delete();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk(tag, exp_q.size(), 0);
        idle(3);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_nonempty", 0, 1);
            end else begin
                logic [2*OUT_W-1:0] e;
                e = exp_q.pop_front();
                chk("out_re", $signed(out_re), $signed(e[2*OUT_W-1:OUT_W]));
                chk("out_im", $signed(out_im), $signed(e[OUT_W-1:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle(2);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        idle(1);

        // Reset configuration: window 1, shift 0.
        send(-5, 9);
        drain("drain_reset_cfg");

        // Basic window with latency check on the fourth sample.
        do_flush(4, 0);
        chk("flush_out_valid", out_valid, 0);
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_re = DATA_W'(i);
            in_im = '0;
            model_in(i, 0, 1'b1);
            @(negedge clk);
            if (i == 5) chk("latency_t1", out_valid, 0);
            if (i == 6) chk("latency_t2", out_valid, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain("drain_basic");
        chk("empty_out_re", out_re, 0);

        // Shift with floor: -13 >>> 1 = -7.
        do_flush(4, 1);
        send(-3, 3); send(-3, 3); send(-3, 3); send(-4, 4);
        drain("drain_shift");

        // Narrowing of a full-scale 64-sample window.
        do_flush(64, 0);
        for (int i = 0; i < 64; i++) send(32767, -32768);
        drain("drain_narrow");

        // Backpressure: FIFO holds results 1..4; 5 and 6 are dropped.
        out_ready = 1'b0;
        do_flush(1, 0);
        for (int i = 1; i <= 4; i++) send(i, -i);
        idle(2);
        chk("bp_valid", out_valid, 1);
        chk("bp_head_re", $signed(out_re), 1);
        send(5, -5, 1'b0);
        chk("ovr_before_drop", overrun, 0);
        idle(1);
        chk("ovr_after_drop", overrun, 1);
        send(6, -6, 1'b0);
        idle(2);
        chk("bp_head_stable", $signed(out_re), 1);
        out_ready = 1'b1;
        drain("drain_bp");
        chk("bp_empty", out_valid, 0);
        chk("ovr_sticky", overrun, 1);

        // Flush discards a result still in the pipeline.
        do_flush(1, 0);
        chk("ovr_cleared", overrun, 0);
        send(7, 7, 1'b0);
        do_flush(1, 0);
        idle(3);
        chk("pipe_discard", out_valid, 0);

        // Flush mid-window with a coincident, discarded sample.
        do_flush(4, 0);
        send(1, 0); send(2, 0);
        do_flush(4, 0, 1'b1, 3);
        for (int i = 0; i < 4; i++) send(5, 0);
        drain("drain_flush_mid");
        chk("flush_mid_ovr", overrun, 0);

        // Long run across write-pointer wraps.
        do_flush(64, 0);
        for (int k = 0; k < 200; k++) send(k % 7, -(k % 5));
        drain("drain_wrap");
        chk("wrap_ovr", overrun, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
